// File: rtl/data_mem_arbiter_if.sv
// Bundles the CPU, external-master and RAM-side signals of the data-memory arbiter.
// The arbiter uses the slave modport; the surrounding system uses the master modport.
interface data_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          ext_valid;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_last;
  logic          ext_ready;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_valid, ext_we, ext_addr, ext_wdata, ext_last,
    output ext_ready, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_valid, ext_we, ext_addr, ext_wdata, ext_last,
    input  ext_ready, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU (fixed priority) and an external master.
// Define ARB_STARVE_GUARD_EN to force an E grant after STARVE_LIM consecutive waiting cycles.
module data_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIM = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    C_RD  = 2'd1,
    E_OWN = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [BW-1:0] beat_cnt_q;
  logic [BW-1:0] beat_cnt_d;
  logic          cap_q;
  logic          cap_d;
  logic          rvalid_q;
  logic          ext_force;
  logic          ext_accept;

  logic [DW-1:0] cpu_rdata_c;
  logic          cpu_stall_c;
  logic          ext_ready_c;
  logic          mem_en_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;

  assign ext_accept = bus.ext_valid && ext_ready_c;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] starve_cnt_q;

  assign ext_force = bus.ext_valid && (starve_cnt_q == SW'(STARVE_LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else if (ext_accept) begin
      starve_cnt_q <= '0;
    end else if (bus.ext_valid && (starve_cnt_q != SW'(STARVE_LIM))) begin
      starve_cnt_q <= starve_cnt_q + SW'(1);
    end
  end
`else
  assign ext_force = 1'b0;
`endif

  // cap_q marks the IDLE cycle right after a burst was cut at MAX_BURST, leaving the RAM to the CPU.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cap_d       = 1'b0;
    cpu_rdata_c = '0;
    cpu_stall_c = 1'b0;
    ext_ready_c = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req && !ext_force) begin
          mem_en_c    = 1'b1;
          mem_we_c    = bus.cpu_we;
          mem_addr_c  = bus.cpu_addr;
          mem_wdata_c = bus.cpu_wdata;
          if (!bus.cpu_we) begin
            cpu_stall_c = 1'b1;
            state_d     = C_RD;
          end
        end else if (bus.ext_valid && (!cap_q || ext_force)) begin
          ext_ready_c = 1'b1;
          cpu_stall_c = bus.cpu_req;
          mem_en_c    = 1'b1;
          mem_we_c    = bus.ext_we;
          mem_addr_c  = bus.ext_addr;
          mem_wdata_c = bus.ext_wdata;
          if (bus.ext_last || (MAX_BURST == 1)) begin
            beat_cnt_d = '0;
            cap_d      = !bus.ext_last;
          end else begin
            beat_cnt_d = BW'(1);
            state_d    = E_OWN;
          end
        end
      end

      C_RD: begin
        cpu_rdata_c = bus.mem_rdata;
        state_d     = IDLE;
      end

      E_OWN: begin
        cpu_stall_c = bus.cpu_req;
        if (bus.ext_valid) begin
          ext_ready_c = 1'b1;
          mem_en_c    = 1'b1;
          mem_we_c    = bus.ext_we;
          mem_addr_c  = bus.ext_addr;
          mem_wdata_c = bus.ext_wdata;
          if (bus.ext_last || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            cap_d      = !bus.ext_last;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end else begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end

      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      cap_q      <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      cap_q      <= cap_d;
      rvalid_q   <= ext_accept && !bus.ext_we;
    end
  end

  // Outputs are forced low while reset is held so nothing leaks from an abandoned transfer.
  assign bus.cpu_rdata  = rst ? cpu_rdata_c : '0;
  assign bus.cpu_stall  = rst && cpu_stall_c;
  assign bus.ext_ready  = rst && ext_ready_c;
  assign bus.ext_rvalid = rst && rvalid_q;
  assign bus.ext_rdata  = (rst && rvalid_q) ? bus.mem_rdata : '0;
  assign bus.mem_en     = rst && mem_en_c;
  assign bus.mem_we     = rst && mem_we_c;
  assign bus.mem_addr   = rst ? mem_addr_c : '0;
  assign bus.mem_wdata  = rst ? mem_wdata_c : '0;

endmodule
